spi_reg_master: RTL and testbench
=================================

SPI_REG_MASTER -- requirements
Module: spi_reg_master

Interface
REQ-001 Parameter HALF_DIV, default 3: sys_clk cycles per SPI half-period; legal range 2..255.
REQ-002 Parameter DUMMY_CYCLES, default 8: SPI clocks between the address and data phases.
REQ-003 sys_clk  input  1: single clock; all logic is on its rising edge.
REQ-004 rst_n  input  1: reset, asynchronous assert, active-low.
REQ-005 cmd_valid  input  1: command request.
REQ-006 cmd_ready  output  1: command accepted when cmd_valid and cmd_ready are both high on a clock edge.
REQ-007 cmd_read  input  1: 1 = read, 0 = write.
REQ-008 cmd_addr  input  7: register address.
REQ-009 cmd_wdata  input  16: write data; shifted out during reads as well.
REQ-010 rsp_valid  output  1: single-cycle pulse at frame end.
REQ-011 rsp_rdata  output  16: data captured from MISO, valid while rsp_valid is high and held until the next pulse.
REQ-012 spi_clk  output  1: SPI clock, mode 0 (idles low).
REQ-013 spi_mosi  output  1: serial data to the slave.
REQ-014 spi_miso  input  1: serial data from the slave.
REQ-015 spi_cs_n  output  1: chip select, active-low.

Function
REQ-016 Frame SHALL be MSB-first, 32 SPI clocks total: R/~W bit, cmd_addr[6:0], DUMMY_CYCLES bits of 0, then data[15:0].
REQ-017 cmd_ready SHALL be high only in IDLE; cmd_read, cmd_addr and cmd_wdata SHALL be registered on acceptance, and later input changes SHALL be ignored.
REQ-018 FSM states SHALL be IDLE, SETUP, CLK_HI, CLK_LO, HOLD, GAP.
REQ-019 Acceptance SHALL move the FSM to SETUP; on the next cycle spi_cs_n=0, spi_mosi=R/~W bit, spi_clk=0.
REQ-020 SETUP and CLK_LO SHALL each last HALF_DIV cycles, then spi_clk rises (CLK_HI); the slave samples MOSI on this edge.
REQ-021 CLK_HI SHALL last HALF_DIV cycles, then spi_clk falls; on that same cycle spi_mosi advances to the next bit.
REQ-022 During the data phase, spi_miso SHALL be shifted into the receive register on the sys_clk edge that drives spi_clk low.
REQ-023 After the 32nd falling edge the FSM SHALL enter HOLD for HALF_DIV cycles, with spi_cs_n still 0 and spi_mosi=0.
REQ-024 On leaving HOLD: spi_cs_n=1, rsp_valid pulses for exactly 1 cycle, and rsp_rdata updates; this applies to writes as well.
REQ-025 GAP SHALL keep spi_cs_n=1 for 2*HALF_DIV cycles before IDLE, guaranteeing the minimum CS-high time between frames.
REQ-026 Frame length from acceptance to return to IDLE SHALL be 1 + 67*HALF_DIV cycles with the default DUMMY_CYCLES.
REQ-027 cmd_valid held high continuously SHALL produce back-to-back frames, each separated by the GAP.
REQ-028 The bit counter SHALL be 6 bits wide and terminate at exactly 32; no wrap-around into a 33rd clock.

Reset
REQ-029 rst_n low SHALL immediately and asynchronously force: spi_cs_n=1, spi_clk=0, spi_mosi=0, rsp_valid=0, rsp_rdata=0, cmd_ready=0, FSM=IDLE, counters=0.
REQ-030 cmd_ready SHALL go high on the first clock after rst_n deasserts.
REQ-031 Reset mid-frame SHALL abort the frame with no rsp_valid pulse; the next accepted command SHALL produce a complete, correct frame.

Structure
REQ-032 Package spi_reg_pkg SHALL hold ADDR_W=7, DATA_W=16, FRAME_BITS, and the FSM state enum; the testbench slave model SHALL share it.
REQ-033 One sub-module, spi_reg_halftick, SHALL generate the HALF_DIV strobe; it is reloaded on each state entry.

Verification
REQ-034 Write, addr 0x00, data 0xAAAA, HALF_DIV=3 -> MOSI sampled on rising edges = 0, 0000000, 8x0, 1010101010101010; exactly 32 rising edges; one rsp_valid pulse.
REQ-035 Read, addr 0x05, slave model returns 0x5555 -> rsp_rdata=0x5555 on the rsp_valid cycle; cs_n high afterwards.
REQ-036 Loopback against a register-slave model: write-then-read of 0x2A2A, 0x8000, 0x0001 and 0xFFFF at addr 0x7F -> each readback matches the written value.
REQ-037 cmd_valid held high for 3 commands -> cmd_ready low throughout each frame, CS-high gap >= 6 cycles, 3 rsp_valid pulses.
REQ-038 rst_n pulsed low during the 20th SPI clock -> spi_cs_n=1 and spi_clk=0 without waiting for a clock edge, no rsp_valid; next write of 0x1234 is bit-exact.
REQ-039 HALF_DIV=2 -> frame length from acceptance to IDLE is 135 cycles; spi_clk high and low periods are each 2 cycles.

Source files
------------

// File: rtl/spi_reg_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : spi_reg_pkg
//  Purpose  : Shared constants and FSM state encoding for the SPI register
//             master and any slave model talking to it.
//  Contents : ADDR_W, DATA_W, FRAME_BITS, CNT_W, state_t
//  Revision : 1.0 - initial release
// ============================================================================
package spi_reg_pkg;

    localparam int ADDR_W        = 7;
    localparam int DATA_W        = 16;
    localparam int DUMMY_DEFAULT = 8;
    // R/~W bit + address + dummy bits + data bits
    localparam int FRAME_BITS    = 1 + ADDR_W + DUMMY_DEFAULT + DATA_W;
    // Bit counter width; counts completed falling edges 0..FRAME_BITS
    localparam int CNT_W         = 6;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETUP  = 3'd1,
        ST_CLK_HI = 3'd2,
        ST_CLK_LO = 3'd3,
        ST_HOLD   = 3'd4,
        ST_GAP    = 3'd5
    } state_t;

endpackage
`default_nettype wire

// File: rtl/spi_reg_halftick.sv
`default_nettype none
// ============================================================================
//  Module   : spi_reg_halftick
//  Purpose  : Half-period strobe generator. o_tick is high during the
//             HALF_DIV-th cycle after the last reload, so a state entered
//             on a reload edge lasts exactly HALF_DIV cycles. The counter
//             also restarts after each tick, giving a periodic strobe.
//  Ports    : clk     - system clock
//             rst_n   - asynchronous active-low reset
//             i_load  - restart the count (asserted on each state entry)
//             o_tick  - half-period strobe
//  Revision : 1.0 - initial release
// ============================================================================
module spi_reg_halftick #(
    parameter int HALF_DIV = 3
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_load,
    output logic o_tick
);

    logic [7:0] r_cnt;

    assign o_tick = (r_cnt == 8'(HALF_DIV - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_load || o_tick) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 8'd1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/spi_reg_master.sv
`default_nettype none
// ============================================================================
//  Module   : spi_reg_master
//  Purpose  : SPI mode-0 register-access master. Each accepted command
//             produces one 32-clock MSB-first frame: R/~W, address, dummy
//             zeros, 16 data bits. MISO is captured during the data phase
//             and returned with a one-cycle rsp_valid pulse.
//  Ports    : sys_clk, rst_n            - clock, async active-low reset
//             cmd_valid/cmd_ready       - command handshake
//             cmd_read/addr/wdata       - command fields
//             rsp_valid/rsp_rdata       - frame-end response
//             spi_clk/mosi/miso/cs_n    - SPI bus
//  Revision : 1.0 - initial release
// ============================================================================
module spi_reg_master
    import spi_reg_pkg::*;
#(
    parameter int HALF_DIV     = 3,
    parameter int DUMMY_CYCLES = 8
) (
    input  logic              sys_clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_read,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              spi_clk,
    output logic              spi_mosi,
    input  logic              spi_miso,
    output logic              spi_cs_n
);

    localparam int c_frame_bits = 1 + ADDR_W + DUMMY_CYCLES + DATA_W;
    localparam logic [CNT_W-1:0] c_last_bit   = CNT_W'(c_frame_bits - 1);
    localparam logic [CNT_W-1:0] c_data_first = CNT_W'(c_frame_bits - DATA_W);

    state_t                  r_state;
    state_t                  w_next_state;
    logic                    r_ready;
    logic                    r_gap_half;
    logic [CNT_W-1:0]        r_bit_cnt;
    logic [c_frame_bits-1:0] r_shift;
    logic [DATA_W-1:0]       r_rx;
    logic [DATA_W-1:0]       r_rdata;
    logic                    r_rsp_valid;
    logic                    r_sclk;
    logic                    r_mosi;
    logic                    r_cs_n;
    logic                    w_tick;
    logic                    w_load;
    logic                    w_accept;
    logic                    w_last_bit;

    assign w_accept   = (r_state == ST_IDLE) && cmd_valid && r_ready;
    assign w_last_bit = (r_bit_cnt == c_last_bit);
    assign w_load     = (w_next_state != r_state);

    spi_reg_halftick #(
        .HALF_DIV (HALF_DIV)
    ) u_halftick (
        .clk    (sys_clk),
        .rst_n  (rst_n),
        .i_load (w_load),
        .o_tick (w_tick)
    );

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE:   if (w_accept) w_next_state = ST_SETUP;
            ST_SETUP:  if (w_tick)   w_next_state = ST_CLK_HI;
            ST_CLK_HI: if (w_tick)   w_next_state = w_last_bit ? ST_HOLD : ST_CLK_LO;
            ST_CLK_LO: if (w_tick)   w_next_state = ST_CLK_HI;
            ST_HOLD:   if (w_tick)   w_next_state = ST_GAP;
            // GAP spans two half-periods; r_gap_half marks the second one
            ST_GAP:    if (w_tick && r_gap_half) w_next_state = ST_IDLE;
            default:   w_next_state = ST_IDLE;
        endcase
    end

    // All bus outputs are registered so they change cleanly on state edges.
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ready     <= 1'b0;
            r_gap_half  <= 1'b0;
            r_bit_cnt   <= '0;
            r_shift     <= '0;
            r_rx        <= '0;
            r_rdata     <= '0;
            r_rsp_valid <= 1'b0;
            r_sclk      <= 1'b0;
            r_mosi      <= 1'b0;
            r_cs_n      <= 1'b1;
        end else begin
            r_rsp_valid <= 1'b0;
            // Ready only while the FSM sits in IDLE; held low for the first
            // cycle after reset release.
            r_ready     <= (w_next_state == ST_IDLE);
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_shift   <= {cmd_read, cmd_addr, {DUMMY_CYCLES{1'b0}}, cmd_wdata};
                        r_cs_n    <= 1'b0;
                        r_mosi    <= cmd_read;
                        r_sclk    <= 1'b0;
                        r_bit_cnt <= '0;
                        r_rx      <= '0;
                    end
                end
                ST_SETUP, ST_CLK_LO: begin
                    if (w_tick) r_sclk <= 1'b1;
                end
                ST_CLK_HI: begin
                    if (w_tick) begin
                        r_sclk    <= 1'b0;
                        r_bit_cnt <= r_bit_cnt + 1'b1;
                        // Slave drives MISO from its previous falling edge,
                        // so it is still stable on the edge we pull SCLK low.
                        if (r_bit_cnt >= c_data_first) begin
                            r_rx <= {r_rx[DATA_W-2:0], spi_miso};
                        end
                        r_shift <= r_shift << 1;
                        r_mosi  <= w_last_bit ? 1'b0 : r_shift[c_frame_bits-2];
                    end
                end
                ST_HOLD: begin
                    if (w_tick) begin
                        r_cs_n      <= 1'b1;
                        r_rsp_valid <= 1'b1;
                        r_rdata     <= r_rx;
                    end
                end
                ST_GAP: begin
                    if (w_tick) r_gap_half <= ~r_gap_half;
                end
                default: ;
            endcase
        end
    end

    assign cmd_ready = r_ready;
    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = r_rdata;
    assign spi_clk   = r_sclk;
    assign spi_mosi  = r_mosi;
    assign spi_cs_n  = r_cs_n;

endmodule
`default_nettype wire

// File: tb/tb_spi_reg_master.sv
`default_nettype none
// ============================================================================
//  Module   : tb_spi_reg_master
//  Purpose  : Self-checking bench for spi_reg_master with a mode-0
//             register-slave model. Main instance uses HALF_DIV=3; a second
//             instance with HALF_DIV=2 is used for frame timing.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_spi_reg_master;
    import spi_reg_pkg::*;

    logic              sys_clk = 1'b0;
    logic              rst_n;
    logic              cmd_valid, cmd_read;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_wdata;
    logic              cmd_ready, rsp_valid, spi_clk, spi_mosi, spi_cs_n;
    logic [DATA_W-1:0] rsp_rdata;
    logic              spi_miso = 1'b0;

    logic              c2_valid;
    logic              c2_ready, rsp2_valid, spi2_clk, spi2_mosi, spi2_cs_n;
    logic [DATA_W-1:0] rsp2_rdata;
    logic              spi2_miso = 1'b0;

    int tests = 0;
    int fails = 0;
    int rsp_pulses = 0;

    always #5 sys_clk = ~sys_clk;

    spi_reg_master #(.HALF_DIV(3), .DUMMY_CYCLES(8)) dut (
        .sys_clk(sys_clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_read(cmd_read), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .spi_clk(spi_clk),
        .spi_mosi(spi_mosi), .spi_miso(spi_miso), .spi_cs_n(spi_cs_n)
    );

    spi_reg_master #(.HALF_DIV(2), .DUMMY_CYCLES(8)) dut2 (
        .sys_clk(sys_clk), .rst_n(rst_n), .cmd_valid(c2_valid), .cmd_ready(c2_ready),
        .cmd_read(1'b0), .cmd_addr(7'h11), .cmd_wdata(16'h0F0F),
        .rsp_valid(rsp2_valid), .rsp_rdata(rsp2_rdata), .spi_clk(spi2_clk),
        .spi_mosi(spi2_mosi), .spi_miso(spi2_miso), .spi_cs_n(spi2_cs_n)
    );

    // ---------------- register slave model (mode 0) ----------------
    logic [FRAME_BITS-1:0] s_frame = '0;
    int                    s_rises = 0;
    logic                  s_read = 1'b0;
    logic [DATA_W-1:0]     s_word = '0;
    logic [FRAME_BITS-1:0] s_last_frame = '0;
    int                    s_last_rises = 0;
    logic [DATA_W-1:0]     s_regs [0:(1<<ADDR_W)-1];
    logic                  slave_clr = 1'b0;

    // CS falling edge (SCLK low) clears; SCLK rising edge samples MOSI.
    always @(posedge spi_clk or negedge spi_cs_n) begin
        if (!spi_clk) begin
            s_frame <= '0;
            s_rises <= 0;
        end else if (!spi_cs_n) begin
            s_frame <= {s_frame[FRAME_BITS-2:0], spi_mosi};
            s_rises <= s_rises + 1;
        end
    end

    always @(negedge spi_clk) begin
        if (s_rises == ADDR_W + 1) begin
            s_read   <= s_frame[ADDR_W];
            s_word   <= s_regs[s_frame[ADDR_W-1:0]];
            spi_miso <= 1'b0;
        end else if (s_rises >= FRAME_BITS - DATA_W && s_rises < FRAME_BITS) begin
            spi_miso <= s_read ? s_word[FRAME_BITS-1-s_rises] : 1'b0;
        end else begin
            spi_miso <= 1'b0;
        end
    end

    always @(posedge spi_cs_n or posedge slave_clr) begin
        if (slave_clr) begin
            for (int i = 0; i < (1 << ADDR_W); i++) s_regs[i] <= '0;
            s_regs[5] <= 16'h5555;
        end else begin
            s_last_frame <= s_frame;
            s_last_rises <= s_rises;
            if (s_rises == FRAME_BITS && !s_frame[FRAME_BITS-1]) begin
                s_regs[s_frame[FRAME_BITS-2 -: ADDR_W]] <= s_frame[DATA_W-1:0];
            end
        end
    end

    always @(negedge sys_clk) begin
        if (rsp_valid === 1'b1) rsp_pulses <= rsp_pulses + 1;
    end

    // ---------------- checking helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic timeout_fail(input string name);
        tests++;
        fails++;
        $display("FAIL %s: timeout, event not seen within cycle budget", name);
    endtask

    // Issue one command from a negedge; wait for its response and check it.
    task automatic run_cmd(input string name, input logic rd, input logic [6:0] addr,
                           input logic [15:0] wdata, input logic [15:0] exp_rdata,
                           input logic [31:0] exp_frame);
        int n;
        int pulses0;
        logic [15:0] held;
        pulses0   = rsp_pulses;
        cmd_read  = rd;
        cmd_addr  = addr;
        cmd_wdata = wdata;
        cmd_valid = 1'b1;
        n = 0;
        while (!cmd_ready && n < 100) begin @(negedge sys_clk); n++; end
        if (!cmd_ready) begin
            timeout_fail({name, " accept"});
            cmd_valid = 1'b0;
            return;
        end
        @(negedge sys_clk);
        // Scramble inputs after acceptance; the frame must not follow them.
        cmd_valid = 1'b0;
        cmd_read  = ~rd;
        cmd_addr  = ~addr;
        cmd_wdata = ~wdata;
        n = 0;
        while (!rsp_valid && n < 1000) begin @(negedge sys_clk); n++; end
        if (!rsp_valid) begin
            timeout_fail({name, " rsp_valid"});
            return;
        end
        check({name, " rdata"}, 32'(rsp_rdata), 32'(exp_rdata));
        check({name, " cs_n at rsp"}, 32'(spi_cs_n), 32'd1);
        held = rsp_rdata;
        @(negedge sys_clk);
        check({name, " rsp_valid one cycle"}, 32'(rsp_valid), 32'd0);
        check({name, " rdata held"}, 32'(rsp_rdata), 32'(held));
        n = 0;
        while (!cmd_ready && n < 100) begin @(negedge sys_clk); n++; end
        if (!cmd_ready) timeout_fail({name, " return to idle"});
        check({name, " rsp pulses"}, 32'(rsp_pulses - pulses0), 32'd1);
        check({name, " mosi frame"}, s_last_frame, exp_frame);
        check({name, " rising edges"}, 32'(s_last_rises), 32'd32);
    endtask

    typedef struct {
        logic        rd;
        logic [6:0]  addr;
        logic [15:0] wdata;
        logic [15:0] exp_rdata;
        logic [31:0] exp_frame;
    } vec_t;

    vec_t vecs [10];

    initial begin
        int n, accepts, pulses0, ready_bad, gap, min_gap, gaps_seen;
        int run, prev, cur, hi_runs, hi_min, hi_max, lo_min, lo_max;
        bit seen_low, stop_next, done;

        vecs[0] = '{1'b0, 7'h00, 16'hAAAA, 16'h0000, 32'h0000_AAAA};
        vecs[1] = '{1'b1, 7'h05, 16'h0000, 16'h5555, 32'h8500_0000};
        vecs[2] = '{1'b0, 7'h7F, 16'h2A2A, 16'h0000, 32'h7F00_2A2A};
        vecs[3] = '{1'b1, 7'h7F, 16'h1357, 16'h2A2A, 32'hFF00_1357};
        vecs[4] = '{1'b0, 7'h7F, 16'h8000, 16'h0000, 32'h7F00_8000};
        vecs[5] = '{1'b1, 7'h7F, 16'h0000, 16'h8000, 32'hFF00_0000};
        vecs[6] = '{1'b0, 7'h7F, 16'h0001, 16'h0000, 32'h7F00_0001};
        vecs[7] = '{1'b1, 7'h7F, 16'hFFFF, 16'h0001, 32'hFF00_FFFF};
        vecs[8] = '{1'b0, 7'h7F, 16'hFFFF, 16'h0000, 32'h7F00_FFFF};
        vecs[9] = '{1'b1, 7'h7F, 16'h0000, 16'hFFFF, 32'hFF00_0000};

        rst_n = 1'b0; cmd_valid = 1'b0; cmd_read = 1'b0;
        cmd_addr = '0; cmd_wdata = '0; c2_valid = 1'b0;
        #1 slave_clr = 1'b1;
        #1 slave_clr = 1'b0;

        // Reset state
        @(negedge sys_clk);
        check("reset cs_n", 32'(spi_cs_n), 32'd1);
        check("reset spi_clk", 32'(spi_clk), 32'd0);
        check("reset mosi", 32'(spi_mosi), 32'd0);
        check("reset rsp_valid", 32'(rsp_valid), 32'd0);
        check("reset rdata", 32'(rsp_rdata), 32'd0);
        check("reset cmd_ready", 32'(cmd_ready), 32'd0);
        @(negedge sys_clk);
        rst_n = 1'b1;
        #1 check("ready before first edge", 32'(cmd_ready), 32'd0);
        @(negedge sys_clk);
        check("ready after first edge", 32'(cmd_ready), 32'd1);

        // Table-driven single frames
        for (int i = 0; i < 10; i++) begin
            run_cmd($sformatf("vec%0d", i), vecs[i].rd, vecs[i].addr, vecs[i].wdata,
                    vecs[i].exp_rdata, vecs[i].exp_frame);
        end

        // Back-to-back frames with cmd_valid held high
        cmd_read = 1'b0; cmd_addr = 7'h10; cmd_wdata = 16'hBEEF; cmd_valid = 1'b1;
        accepts = 0; pulses0 = rsp_pulses; ready_bad = 0; gap = 0; min_gap = 1000;
        gaps_seen = 0; seen_low = 0; stop_next = 0; done = 0;
        for (int cyc = 0; cyc < 1500 && !done; cyc++) begin
            if (stop_next) cmd_valid = 1'b0;
            if (cmd_valid && cmd_ready) begin
                accepts++;
                if (accepts == 3) stop_next = 1;
            end
            if (!spi_cs_n && cmd_ready) ready_bad++;
            if (spi_cs_n) begin
                if (seen_low) gap++;
            end else begin
                if (seen_low && gap > 0) begin
                    gaps_seen++;
                    if (gap < min_gap) min_gap = gap;
                end
                gap = 0;
                seen_low = 1;
            end
            if (!cmd_valid && rsp_pulses - pulses0 == 3 && cmd_ready) done = 1;
            else @(negedge sys_clk);
        end
        cmd_valid = 1'b0;
        if (!done) timeout_fail("b2b completion");
        check("b2b accepts", 32'(accepts), 32'd3);
        check("b2b rsp pulses", 32'(rsp_pulses - pulses0), 32'd3);
        check("b2b ready during frame", 32'(ready_bad), 32'd0);
        check("b2b gaps seen", 32'(gaps_seen), 32'd2);
        check("b2b min gap >= 6", 32'(min_gap >= 6), 32'd1);

        // Reset pulsed during the 20th SPI clock
        pulses0 = rsp_pulses;
        cmd_read = 1'b0; cmd_addr = 7'h33; cmd_wdata = 16'hFFFF; cmd_valid = 1'b1;
        @(negedge sys_clk);
        cmd_valid = 1'b0;
        n = 0;
        while (!(s_rises == 20 && spi_clk) && n < 1000) begin @(negedge sys_clk); n++; end
        if (!(s_rises == 20 && spi_clk)) timeout_fail("abort reach clock 20");
        #2 rst_n = 1'b0;
        #1;
        check("abort cs_n async", 32'(spi_cs_n), 32'd1);
        check("abort spi_clk async", 32'(spi_clk), 32'd0);
        check("abort cmd_ready", 32'(cmd_ready), 32'd0);
        @(negedge sys_clk);
        @(negedge sys_clk);
        rst_n = 1'b1;
        @(negedge sys_clk);
        @(negedge sys_clk);
        check("abort no rsp pulse", 32'(rsp_pulses - pulses0), 32'd0);
        check("abort no slave write", 32'(s_regs[7'h33]), 32'd0);
        run_cmd("post-abort write", 1'b0, 7'h33, 16'h1234, 16'h0000, 32'h3300_1234);
        run_cmd("post-abort read", 1'b1, 7'h33, 16'h0000, 16'h1234, 32'hB300_0000);

        // HALF_DIV=2 frame length and SCLK phase widths
        check("hd2 ready idle", 32'(c2_ready), 32'd1);
        c2_valid = 1'b1;
        @(negedge sys_clk);
        c2_valid = 1'b0;
        n = 1; run = 0; prev = 2; hi_runs = 0;
        hi_min = 99; hi_max = 0; lo_min = 99; lo_max = 0;
        while (n < 500) begin
            if (c2_ready) break;
            cur = spi2_cs_n ? 2 : int'(spi2_clk);
            if (cur != prev) begin
                if (prev == 1) begin
                    hi_runs++;
                    if (run < hi_min) hi_min = run;
                    if (run > hi_max) hi_max = run;
                end else if (prev == 0) begin
                    if (run < lo_min) lo_min = run;
                    if (run > lo_max) lo_max = run;
                end
                run = 1;
                prev = cur;
            end else begin
                run++;
            end
            @(negedge sys_clk);
            n++;
        end
        if (!c2_ready) timeout_fail("hd2 return to idle");
        check("hd2 frame length", 32'(n), 32'd135);
        check("hd2 high phases", 32'(hi_runs), 32'd32);
        check("hd2 high min", 32'(hi_min), 32'd2);
        check("hd2 high max", 32'(hi_max), 32'd2);
        check("hd2 low min", 32'(lo_min), 32'd2);
        check("hd2 low max", 32'(lo_max), 32'd2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
